// File: rtl/fixed_pkg.sv
// Shared widths, CORDIC gain, arctangent table and FSM states for the CORDIC sin/cos unit.
// All angles and coordinates are signed Q2.23 in 26 bits; results are Q1.23 in 25 bits.
package fixed_pkg;

  localparam int FRAC_W  = 23;
  localparam int ANGLE_W = 26;
  localparam int OUT_W   = 25;
  localparam int CNT_W   = 5;

  // Converged gain 1/prod(sqrt(1+2^-2i)) preloaded into x so no post-scaling is needed.
  localparam logic signed [ANGLE_W-1:0] CORDIC_K = 26'sh04DBA77;

  typedef enum logic {
    IDLE,
    ROTATE
  } state_t;

  // atan(2^-i) in Q2.23, rounded to nearest; beyond i = 9 it equals 2^(23-i).
  function automatic logic [ANGLE_W-1:0] atan_lut(input logic [CNT_W-1:0] idx);
    logic [ANGLE_W-1:0] val;
    val = '0;
    case (idx)
      5'd0:  val = 26'h06487ED;
      5'd1:  val = 26'h03B58CE;
      5'd2:  val = 26'h01F5B76;
      5'd3:  val = 26'h00FEADD;
      5'd4:  val = 26'h007FD57;
      5'd5:  val = 26'h003FFAB;
      5'd6:  val = 26'h001FFF5;
      5'd7:  val = 26'h000FFFF;
      5'd8:  val = 26'h0008000;
      5'd9:  val = 26'h0004000;
      5'd10: val = 26'h0002000;
      5'd11: val = 26'h0001000;
      5'd12: val = 26'h0000800;
      5'd13: val = 26'h0000400;
      5'd14: val = 26'h0000200;
      5'd15: val = 26'h0000100;
      5'd16: val = 26'h0000080;
      5'd17: val = 26'h0000040;
      5'd18: val = 26'h0000020;
      5'd19: val = 26'h0000010;
      5'd20: val = 26'h0000008;
      5'd21: val = 26'h0000004;
      5'd22: val = 26'h0000002;
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_microrotation.sv
// One CORDIC rotation-mode step: rotates (x, y) toward the residual angle z by +-atan(2^-i).
// Purely combinational; shifts are arithmetic and truncate toward minus infinity.
module cordic_microrotation
  import fixed_pkg::*;
(
  input  logic signed [ANGLE_W-1:0] x_i,
  input  logic signed [ANGLE_W-1:0] y_i,
  input  logic signed [ANGLE_W-1:0] z_i,
  input  logic        [CNT_W-1:0]   i_i,
  input  logic        [ANGLE_W-1:0] atan_i,
  output logic signed [ANGLE_W-1:0] x_o,
  output logic signed [ANGLE_W-1:0] y_o,
  output logic signed [ANGLE_W-1:0] z_o
);

  logic signed [ANGLE_W-1:0] x_sh;
  logic signed [ANGLE_W-1:0] y_sh;

  always_comb begin
    x_sh = x_i >>> i_i;
    y_sh = y_i >>> i_i;
    // Non-negative residual rotates counter-clockwise (d = +1).
    if (!z_i[ANGLE_W-1]) begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - $signed(atan_i);
    end else begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + $signed(atan_i);
    end
  end

endmodule

// File: rtl/fixed_cordic_cos.sv
// Iterative CORDIC: cos/sin of a signed 1.23 angle, one micro-rotation per clock.
// Latency ITER cycles from accepted start to done pulse; start ignored while busy, no queuing.
module fixed_cordic_cos
  import fixed_pkg::*;
#(
  parameter int ITER = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              sign_i,
  input  logic              integer_i,
  input  logic [FRAC_W-1:0] fractional_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [OUT_W-1:0]  cos_o,
  output logic [OUT_W-1:0]  sin_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_t                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [ANGLE_W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                      done_q, done_d;
  logic        [OUT_W-1:0]   cos_q, cos_d, sin_q, sin_d;

  logic        [ANGLE_W-1:0] mag;
  logic signed [ANGLE_W-1:0] angle;
  logic signed [ANGLE_W-1:0] x_nx, y_nx, z_nx;

  cordic_microrotation u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .z_i    (z_q),
    .i_i    (cnt_q),
    .atan_i (atan_lut(cnt_q)),
    .x_o    (x_nx),
    .y_o    (y_nx),
    .z_o    (z_nx)
  );

  always_comb begin
    mag     = {{(ANGLE_W-FRAC_W-1){1'b0}}, integer_i, fractional_i};
    angle   = sign_i ? -$signed(mag) : $signed(mag);
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    done_d  = 1'b0;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ROTATE;
          cnt_d   = '0;
          x_d     = CORDIC_K;
          y_d     = '0;
          z_d     = angle;
        end
      end
      ROTATE: begin
        x_d   = x_nx;
        y_d   = y_nx;
        z_d   = z_nx;
        cnt_d = cnt_q + 1'b1;
        // Results published from the final rotation's outputs on the same edge.
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          cos_d   = x_nx[OUT_W-1:0];
          sin_d   = y_nx[OUT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      done_q  <= done_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign busy_o = (state_q == ROTATE);
  assign done_o = done_q;
  assign cos_o  = cos_q;
  assign sin_o  = sin_q;

endmodule
